// File: rtl/bitwise_result_capture.sv
// bitwise_result_capture: registers one of seven bitwise results per valid/ready
// handshake into a 2-entry buffer. It presents the head entry with zero/parity
// flags and counts delivered results modulo 2^CNT_W.
// Optional feature macro: BITWISE_SEL_ERR_EN. When it is defined, op_sel_in=7
// stores 0 and sets a sticky err_out. Otherwise op_sel_in=7 selects y0_in and
// err_out is tied to 0.
module bitwise_result_capture #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] y0_in,
  input  logic [WIDTH-1:0] y1_in,
  input  logic [WIDTH-1:0] y2_in,
  input  logic [WIDTH-1:0] y3_in,
  input  logic [WIDTH-1:0] y4_in,
  input  logic [WIDTH-1:0] y5_in,
  input  logic [WIDTH-1:0] y6_in,
  input  logic [2:0]       op_sel_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] result_out,
  output logic             zero_out,
  output logic             parity_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] txn_count_out,
  output logic             err_out
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sel_val;
  logic             push, pop;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Handshakes; ready depends only on the state register.
  assign ready_out = (state_q != StFull);
  assign valid_out = (state_q != StEmpty);
  assign push      = valid_in & ready_out;
  assign pop       = valid_out & ready_in;

  // Opcode mux over the seven parallel results.
  always_comb begin
    sel_val = y0_in;
    case (op_sel_in)
      3'd0:    sel_val = y0_in;
      3'd1:    sel_val = y1_in;
      3'd2:    sel_val = y2_in;
      3'd3:    sel_val = y3_in;
      3'd4:    sel_val = y4_in;
      3'd5:    sel_val = y5_in;
      3'd6:    sel_val = y6_in;
`ifdef BITWISE_SEL_ERR_EN
      default: sel_val = '0;
`else
      default: sel_val = y0_in;
`endif
    endcase
  end

  // Occupancy FSM and buffer next-state; head is always the oldest entry.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          head_d  = sel_val;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && !pop) begin
          tail_d  = sel_val;
          state_d = StFull;
        end else if (!push && pop) begin
          // head_q is left as is so result_out holds its last value.
          state_d = StEmpty;
        end else if (push && pop) begin
          head_d  = sel_val;
        end
      end
      StFull: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Delivered-result counter, wraps silently.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = cnt_q + CntOne;
  end

  // State, buffer and counter registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BITWISE_SEL_ERR_EN
  logic err_q, err_d;

  // Sticky illegal-opcode flag, set only by an accepted push.
  always_comb begin
    err_d = err_q | (push & (op_sel_in == 3'd7));
  end

  // Error flag register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  // Flags are forced low while the buffer is empty.
  assign result_out    = head_q;
  assign zero_out      = valid_out & ~(|head_q);
  assign parity_out    = valid_out & (^head_q);
  assign txn_count_out = cnt_q;

endmodule

// File: tb/tb_bitwise_result_capture.sv
// Testbench for bitwise_result_capture: directed vectors with literal
// expectations plus a queue-based reference model checked every falling edge.
module tb_bitwise_result_capture;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic [WIDTH-1:0] ys [7];
  logic [2:0]       op_sel_in = '0;
  logic             valid_in = 1'b0;
  logic             ready_in = 1'b0;
  logic             ready_out, zero_out, parity_out, valid_out, err_out;
  logic [WIDTH-1:0] result_out;
  logic [CNT_W-1:0] txn_count_out;

  int passed = 0;
  int total  = 0;

`ifdef BITWISE_SEL_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  bitwise_result_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .y0_in         (ys[0]),
    .y1_in         (ys[1]),
    .y2_in         (ys[2]),
    .y3_in         (ys[3]),
    .y4_in         (ys[4]),
    .y5_in         (ys[5]),
    .y6_in         (ys[6]),
    .op_sel_in     (op_sel_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .result_out    (result_out),
    .zero_out      (zero_out),
    .parity_out    (parity_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .txn_count_out (txn_count_out),
    .err_out       (err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: FIFO of accepted values, last shown head, pop count, error.
  logic [WIDTH-1:0] mq [$];
  logic [WIDTH-1:0] m_shown;
  logic [CNT_W-1:0] m_cnt;
  bit               m_err;

  function automatic logic [WIDTH-1:0] pick(input logic [2:0] op);
    if (op == 3'd7) return ErrEn ? '0 : ys[0];
    return ys[op];
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mq.delete();
      m_shown = '0;
      m_cnt   = '0;
      m_err   = 1'b0;
    end else begin
      bit do_push, do_pop;
      do_push = valid_in && (mq.size() < 2);
      do_pop  = ready_in && (mq.size() > 0);
      if (do_pop) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (do_push) begin
        mq.push_back(pick(op_sel_in));
        if (op_sel_in == 3'd7 && ErrEn) m_err = 1'b1;
      end
      if (mq.size() > 0) m_shown = mq[0];
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk_in) begin
    bit ev;
    ev = (mq.size() != 0);
    check("m_valid",  32'(valid_out),     32'(ev));
    check("m_ready",  32'(ready_out),     32'(mq.size() < 2));
    check("m_result", 32'(result_out),    32'(m_shown));
    check("m_zero",   32'(zero_out),      32'(ev && (m_shown == '0)));
    check("m_parity", 32'(parity_out),    32'(ev && (^m_shown)));
    check("m_count",  32'(txn_count_out), 32'(m_cnt));
    check("m_err",    32'(err_out),       32'(m_err));
  end

  task automatic cyc(input logic v, input logic [2:0] op, input logic rdy);
    valid_in  = v;
    op_sel_in = op;
    ready_in  = rdy;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] illegal_exp;
    ys[0] = 4'b0001; ys[1] = 4'b1111; ys[2] = 4'b1110; ys[3] = 4'b1010;
    ys[4] = 4'b0000; ys[5] = 4'b0001; ys[6] = 4'b0100;

    // Reset state while reset is held.
    #2;
    check("rst_ready",  32'(ready_out),     32'd1);
    check("rst_valid",  32'(valid_out),     32'd0);
    check("rst_result", 32'(result_out),    32'd0);
    check("rst_zero",   32'(zero_out),      32'd0);
    check("rst_count",  32'(txn_count_out), 32'd0);
    check("rst_err",    32'(err_out),       32'd0);
    #10 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Single pass.
    cyc(1'b1, 3'd2, 1'b1);
    check("sp_valid",  32'(valid_out),  32'd1);
    check("sp_result", 32'(result_out), 32'b1110);
    check("sp_zero",   32'(zero_out),   32'd0);
    check("sp_parity", 32'(parity_out), 32'd1);
    cyc(1'b0, 3'd0, 1'b1);
    check("sp_count",  32'(txn_count_out), 32'd1);
    check("sp_empty",  32'(valid_out),      32'd0);
    check("sp_hold",   32'(result_out),     32'b1110);
    check("sp_parity0", 32'(parity_out),    32'd0);

    // Backpressure fill.
    cyc(1'b1, 3'd0, 1'b0);
    cyc(1'b1, 3'd3, 1'b0);
    check("bp_ready", 32'(ready_out),  32'd0);
    check("bp_head",  32'(result_out), 32'b0001);
    cyc(1'b1, 3'd6, 1'b0);
    check("bp_third", 32'(ready_out),  32'd0);
    cyc(1'b0, 3'd0, 1'b1);
    check("bp_second", 32'(result_out),    32'b1010);
    check("bp_cnt2",   32'(txn_count_out), 32'd2);
    cyc(1'b0, 3'd0, 1'b1);
    check("bp_drained", 32'(valid_out),     32'd0);
    check("bp_cnt3",    32'(txn_count_out), 32'd3);

    // Simultaneous push/pop in ONE, counter wraps 3 -> 0 -> 1.
    cyc(1'b1, 3'd1, 1'b0);
    cyc(1'b1, 3'd4, 1'b1);
    check("pp_result", 32'(result_out),    32'b0000);
    check("pp_zero",   32'(zero_out),      32'd1);
    check("pp_parity", 32'(parity_out),    32'd0);
    check("pp_ready",  32'(ready_out),     32'd1);
    check("wrap_0",    32'(txn_count_out), 32'd0);
    cyc(1'b0, 3'd0, 1'b1);
    check("wrap_1",    32'(txn_count_out), 32'd1);

    // Illegal opcode, then fill to FULL.
    illegal_exp = ErrEn ? 4'b0000 : 4'b0001;
    cyc(1'b1, 3'd7, 1'b0);
    check("ill_result", 32'(result_out), 32'(illegal_exp));
    check("ill_err",    32'(err_out),    32'(ErrEn));
    cyc(1'b1, 3'd2, 1'b0);
    check("ill_sticky", 32'(err_out),    32'(ErrEn));
    check("full_ready", 32'(ready_out),  32'd0);

    // Asynchronous reset while FULL.
    #3 rst_n_in = 1'b0;
    #1;
    check("ar_valid",  32'(valid_out),     32'd0);
    check("ar_count",  32'(txn_count_out), 32'd0);
    check("ar_ready",  32'(ready_out),     32'd1);
    check("ar_err",    32'(err_out),       32'd0);
    check("ar_result", 32'(result_out),    32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Mixed traffic checked by the model.
    for (int i = 0; i < 48; i++) begin
      for (int k = 0; k < 7; k++) ys[k] = 4'((i * 5 + k * 3) % 16);
      cyc(1'b1 && ((i % 3) != 1), 3'((i * 3) % 8), (i % 4) != 0);
    end
    cyc(1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 1'b1);
    check("end_empty", 32'(valid_out), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bitwise_result_capture.md
Name: bitwise_result_capture

Overview:
- Downstream of the 4-bit combinational bitwise-operator stage.
- Takes that stage's seven parallel results y0..y6. On each valid/ready handshake it selects one result by opcode and registers it.
- Holds accepted results in a 2-entry output buffer and presents them with zero/parity flags to the consumer.
- Keeps a wrapping count of delivered results. Gives the combinational stage a clocked, flow-controlled output.

Parameters:
- WIDTH, 4, width of each bitwise result and of result_out.
- CNT_W, 8, width of the delivered-transaction counter.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- y0_in..y6_in  input  WIDTH each  seven results from the bitwise stage.
- op_sel_in  input  3  result select: k picks yk_in, for k = 0..6.
- valid_in  input  1  upstream has a selectable result this cycle.
- ready_out  output  1  block can accept a result this cycle.
- result_out  output  WIDTH  head-of-buffer result.
- zero_out  output  1  result_out == 0; valid only while valid_out is high.
- parity_out  output  1  XOR-reduce of result_out.
- valid_out  output  1  result_out holds a result.
- ready_in  input  1  downstream accepts result_out this cycle.
- txn_count_out  output  CNT_W  number of results popped downstream, modulo 2^CNT_W.
- err_out  output  1  sticky illegal-opcode flag (see Optional Feature).

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-low.
  - On reset assert, immediately: occupancy=EMPTY, valid_out=0, result_out=0, zero_out=0, parity_out=0, txn_count_out=0, err_out=0.
  - ready_out=1 during and after reset.
- Handshakes:
  - push = valid_in & ready_out.
  - pop = valid_out & ready_in.
- Occupancy FSM, states EMPTY, ONE, FULL:
  - EMPTY: push -> ONE.
  - ONE: push&!pop -> FULL; !push&pop -> EMPTY; push&pop -> ONE, with the new entry becoming head.
  - FULL: pop -> ONE. Push is impossible in FULL.
- ready_out = (state != FULL). It is decoded combinationally from the state register only, never from ready_in.
- valid_out = (state != EMPTY). It is registered.
- Latency:
  - A result pushed at edge N appears on result_out after edge N when the buffer was EMPTY, or ONE with a simultaneous pop.
  - Otherwise it waits behind the head entry.
- Selection:
  - The captured value is y[op_sel_in], sampled at the push edge.
  - The y inputs are not sampled when no push occurs.
- Flags:
  - zero_out and parity_out are derived from result_out.
  - They are 0 while valid_out=0. result_out itself holds its last value when empty, or 0 after reset.
- Counter:
  - txn_count_out increments by 1 on every pop.
  - It wraps from 2^CNT_W-1 to 0 with no flag.
- Stability: while valid_out=1 and ready_in=0, result_out and the flags stay stable. FIFO order is preserved.
- Reset mid-operation: all buffered entries are discarded and the counter clears. No partial state survives.

Optional Feature:
- Macro: BITWISE_SEL_ERR_EN.
- Defined:
  - op_sel_in=7 on a push stores 0 as the result.
  - err_out sets to 1 and stays at 1 until reset.
  - The push is still accepted and counted when popped.
- Undefined:
  - op_sel_in=7 selects y0_in.
  - err_out is tied to 0.

Test Plan:
- Single pass:
  - Stimulus: reset, then drive y0..y6 = 0001,1111,1110,1010,0000,0001,0100; op_sel=2; push one cycle; ready_in=1.
  - Response: next cycle valid_out=1, result_out=1110, zero_out=0, parity_out=1; txn_count_out=1 after the pop.
- Backpressure fill:
  - Stimulus: ready_in=0; push op_sel=0 then op_sel=3; attempt a third push.
  - Response: ready_out=0 after the second push; the third push is not accepted; on ready_in=1, 0001 then 1010 appear in order.
- Simultaneous push/pop:
  - Stimulus: in state ONE, push op_sel=4 with ready_in=1.
  - Response: state stays ONE; result_out=0000, zero_out=1, parity_out=0.
- Counter wrap:
  - Stimulus: with CNT_W=2, five pops.
  - Response: txn_count_out sequence 1,2,3,0,1.
- Reset mid-operation:
  - Stimulus: FULL with ready_in=0; assert rst_n_in low off a clock edge.
  - Response: valid_out=0, txn_count_out=0 and ready_out=1 immediately, without waiting for an edge.
- Illegal opcode:
  - Stimulus: push with op_sel=7.
  - Response with BITWISE_SEL_ERR_EN: result_out=0000 and err_out=1, sticky.
  - Response without it: result_out=y0_in and err_out=0.
